// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the EX stage (port 0)
// and a background requester (port 1). Port 0 has fixed priority. A wait
// counter lets port 1 win once it has lost MAX_WAIT eligible cycles in a row.
// Each port has a single registered result slot with a valid/ready handshake.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALUADD
`define ALUADD 4'd0
`define ALUSUB 4'd1
`define ALUAND 4'd2
`define ALUOR  4'd3
`define ALUXOR 4'd4
`define ALUSLT 4'd5
`define ALUEQU 4'd6
`endif

module alu_arbiter #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // request port 0
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [3:0]            req0_ctr,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  // request port 1
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [3:0]            req1_ctr,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  // response port 0
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp0_zero,
  // response port 1
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp1_zero,
  // shared ALU
  output logic [3:0]            alu_ctr,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_zero,
  // status
  output logic [7:0]            starve_cnt
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [7:0] CNT_MAX    = 8'd255;

  logic free0_s;
  logic free1_s;
  logic elig0_s;
  logic elig1_s;
  logic starved_s;
  logic grant0_s;
  logic grant1_s;

  // Eligibility and grant: port 1 wins when starved or when port 0 is idle.
  // Grants are held off while reset is asserted so the ALU drive stays idle.
  always_comb begin
    free0_s   = ~rsp0_valid | rsp0_ready;
    free1_s   = ~rsp1_valid | rsp1_ready;
    elig0_s   = rst_n & req0_valid & free0_s;
    elig1_s   = rst_n & req1_valid & free1_s;
    starved_s = (starve_cnt >= MAX_WAIT_C);
    if (elig1_s && (starved_s || !elig0_s)) begin
      grant1_s = 1'b1;
    end else begin
      grant1_s = 1'b0;
    end
    grant0_s = elig0_s & ~grant1_s;
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Route the granted port's operands to the ALU; idle drive is all zeros.
  always_comb begin
    alu_ctr = 4'd0;
    alu_a   = {DATA_WIDTH{1'b0}};
    alu_b   = {DATA_WIDTH{1'b0}};
    if (grant1_s) begin
      alu_ctr = req1_ctr;
      alu_a   = req1_a;
      alu_b   = req1_b;
    end else if (grant0_s) begin
      alu_ctr = req0_ctr;
      alu_a   = req0_a;
      alu_b   = req0_b;
    end else begin
      alu_ctr = 4'd0;
      alu_a   = {DATA_WIDTH{1'b0}};
      alu_b   = {DATA_WIDTH{1'b0}};
    end
  end

  // Port 0 result slot: load on grant, release after the consumer accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= {DATA_WIDTH{1'b0}};
      rsp0_zero  <= 1'b0;
    end else if (grant0_s) begin
      rsp0_valid <= 1'b1;
      rsp0_data  <= alu_out;
      rsp0_zero  <= alu_zero;
    end else if (rsp0_ready) begin
      rsp0_valid <= 1'b0;
    end else begin
      rsp0_valid <= rsp0_valid;
    end
  end

  // Port 1 result slot: load on grant, release after the consumer accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp1_valid <= 1'b0;
      rsp1_data  <= {DATA_WIDTH{1'b0}};
      rsp1_zero  <= 1'b0;
    end else if (grant1_s) begin
      rsp1_valid <= 1'b1;
      rsp1_data  <= alu_out;
      rsp1_zero  <= alu_zero;
    end else if (rsp1_ready) begin
      rsp1_valid <= 1'b0;
    end else begin
      rsp1_valid <= rsp1_valid;
    end
  end

  // Port 1 wait counter: counts eligible cycles lost to port 0, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 8'd0;
    end else if (grant1_s || !req1_valid) begin
      starve_cnt <= 8'd0;
    end else if (elig1_s && grant0_s) begin
      if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + 8'd1;
      end else begin
        starve_cnt <= starve_cnt;
      end
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

endmodule
